// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//   Data-memory responder on the far side of the datapath load/store
//   interface. Serves LDR/STR/LDRB/STRB over a req/ack handshake and inserts
//   LATENCY wait states between accept and acknowledge, so a stalling core can
//   be exercised against slow memory. Holds a word-organised RAM; byte stores
//   are merged into the addressed word internally.
//
// Parameters
//   ADDR_W   word-index width, RAM depth = 2**ADDR_W words of 32 bits
//   LATENCY  wait-state cycles between accept and ack (0..15)
//   LAT_W    wait-state counter width, must hold LATENCY
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   MemReq     access request, sampled only while idle
//   MemWrite   1 = store, 0 = load (latched on accept)
//   ByteOp     1 = byte access, 0 = word access (latched on accept)
//   Addr       byte address; [ADDR_W+1:2] = word index, [1:0] = byte lane
//   WriteData  store data; byte stores use [7:0] (latched on accept)
//   ReadData   load result, held until the next load completes
//   MemAck     one-cycle completion pulse
//   Busy       high from accept until the cycle after MemAck
// -----------------------------------------------------------------------------
module dmem_responder #(
   parameter int unsigned ADDR_W  = 6,
   parameter int unsigned LATENCY = 2,
   parameter int unsigned LAT_W   = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemReq,
   input  logic        MemWrite,
   input  logic        ByteOp,
   input  logic [31:0] Addr,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        MemAck,
   output logic        Busy
);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      COMMIT,
      DONE
   } state_t;

   state_t             state;
   logic [LAT_W-1:0]   count;

   // Access captured at accept time
   logic               is_write;
   logic               is_byte;
   logic [ADDR_W-1:0]  index;
   logic [1:0]         lane;
   logic [31:0]        wdata;

   logic [31:0]        mem [2**ADDR_W];

   logic [31:0]        word;
   logic [31:0]        merged;
   logic [7:0]         rbyte;

   // Upper address bits are deliberately ignored: addresses wrap.
   logic               addr_unused;
   assign addr_unused = ^Addr[31:ADDR_W+2];

   // Addressed word, byte-lane merge for STRB and lane extract for LDRB.
   always_comb begin
      word   = mem[index];
      merged = word;
      merged[{lane, 3'b000} +: 8] = wdata[7:0];
      rbyte  = word[{lane, 3'b000} +: 8];
   end

   // RAM write happens on the COMMIT edge only; a reset on that same edge
   // aborts the access, so the write is gated by reset.
   always_ff @(posedge clk) begin
      if (!reset && state == COMMIT && is_write) begin
         mem[index] <= is_byte ? merged : wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         count    <= '0;
         ReadData <= '0;
         MemAck   <= 1'b0;
         Busy     <= 1'b0;
         is_write <= 1'b0;
         is_byte  <= 1'b0;
         index    <= '0;
         lane     <= '0;
         wdata    <= '0;
      end else begin
         MemAck <= 1'b0;
         case (state)
            IDLE: begin
               if (MemReq) begin
                  is_write <= MemWrite;
                  is_byte  <= ByteOp;
                  index    <= Addr[ADDR_W+1:2];
                  lane     <= Addr[1:0];
                  wdata    <= WriteData;
                  count    <= '0;
                  Busy     <= 1'b1;
                  state    <= (LATENCY == 0) ? COMMIT : BUSY;
               end
            end
            BUSY: begin
               count <= count + 1'b1;
               if (count == LAT_W'(LATENCY - 1)) begin
                  state <= COMMIT;
               end
            end
            COMMIT: begin
               if (!is_write) begin
                  ReadData <= is_byte ? {24'b0, rbyte} : word;
               end
               MemAck <= 1'b1;
               state  <= DONE;
            end
            DONE: begin
               Busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               Busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//   Drives two responders (LATENCY=2 and LATENCY=0) with the same directed
//   access sequence. A timing/memory model predicts MemAck, Busy and ReadData
//   every cycle; literal expectations pin the model on the key scenarios.
//   Cycle numbering: cyc is incremented on every rising edge; an access
//   accepted on edge k is acknowledged during cycle k+LATENCY+1 of this count,
//   which is the 4th (LATENCY=2) / 2nd (LATENCY=0) cycle counting the request
//   cycle itself as cycle 0.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        MemReq;
   logic        MemWrite;
   logic        ByteOp;
   logic [31:0] Addr;
   logic [31:0] WriteData;

   logic [31:0] rd_a, rd_b;
   logic        ack_a, ack_b;
   logic        busy_a, busy_b;

   dmem_responder #(.ADDR_W(6), .LATENCY(2), .LAT_W(4)) u_lat2 (
      .clk(clk), .reset(reset), .MemReq(MemReq), .MemWrite(MemWrite),
      .ByteOp(ByteOp), .Addr(Addr), .WriteData(WriteData),
      .ReadData(rd_a), .MemAck(ack_a), .Busy(busy_a)
   );

   dmem_responder #(.ADDR_W(6), .LATENCY(0), .LAT_W(4)) u_lat0 (
      .clk(clk), .reset(reset), .MemReq(MemReq), .MemWrite(MemWrite),
      .ByteOp(ByteOp), .Addr(Addr), .WriteData(WriteData),
      .ReadData(rd_b), .MemAck(ack_b), .Busy(busy_b)
   );

   int vectors    = 0;
   int miscompares = 0;
   int cyc        = 0;
   bit checking   = 1'b0;

   int lat [2] = '{2, 0};

   // ---------------- model ----------------
   bit          act    [2];
   int          acc    [2];
   bit          m_we   [2];
   bit          m_bo   [2];
   logic [31:0] m_addr [2];
   logic [31:0] m_wd   [2];
   logic [31:0] mrd    [2];
   logic [31:0] mm     [2][64];
   int          m_idx;
   int          m_sh;
   logic [31:0] m_mask;

   always @(posedge clk) begin
      cyc++;
      for (int d = 0; d < 2; d++) begin
         if (reset) begin
            act[d] = 1'b0;
            mrd[d] = 32'h0;
         end else begin
            if (act[d] && cyc == acc[d] + lat[d] + 1) begin
               m_idx  = int'(m_addr[d] / 4) % 64;
               m_sh   = 8 * int'(m_addr[d] % 4);
               m_mask = 32'hFF << m_sh;
               if (m_we[d]) begin
                  if (m_bo[d])
                     mm[d][m_idx] = (mm[d][m_idx] & ~m_mask) | ((m_wd[d] & 32'hFF) << m_sh);
                  else
                     mm[d][m_idx] = m_wd[d];
               end else begin
                  if (m_bo[d])
                     mrd[d] = (mm[d][m_idx] >> m_sh) & 32'hFF;
                  else
                     mrd[d] = mm[d][m_idx];
               end
            end
            if (MemReq && (!act[d] || cyc >= acc[d] + lat[d] + 3)) begin
               act[d]    = 1'b1;
               acc[d]    = cyc;
               m_we[d]   = MemWrite;
               m_bo[d]   = ByteOp;
               m_addr[d] = Addr;
               m_wd[d]   = WriteData;
            end
         end
      end
   end

   // ---------------- checking ----------------
   int ackcnt   [2] = '{0, 0};
   int last_ack [2] = '{-1, -1};

   task automatic chk(input string name, input int d, input logic [31:0] got,
                      input logic [31:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s lat%0d cyc=%0d got=%h want=%h", name, lat[d], cyc, got, want);
      end
   endtask

   function automatic logic exp_ack(input int d);
      return act[d] && cyc == acc[d] + lat[d] + 1;
   endfunction

   function automatic logic exp_busy(input int d);
      return act[d] && cyc <= acc[d] + lat[d] + 1;
   endfunction

   always @(negedge clk) begin
      if (checking) begin
         chk("ack",  0, {31'b0, ack_a},  {31'b0, exp_ack(0)});
         chk("busy", 0, {31'b0, busy_a}, {31'b0, exp_busy(0)});
         chk("rd",   0, rd_a, mrd[0]);
         chk("ack",  1, {31'b0, ack_b},  {31'b0, exp_ack(1)});
         chk("busy", 1, {31'b0, busy_b}, {31'b0, exp_busy(1)});
         chk("rd",   1, rd_b, mrd[1]);
         if (ack_a === 1'b1) begin ackcnt[0]++; last_ack[0] = cyc; end
         if (ack_b === 1'b1) begin ackcnt[1]++; last_ack[1] = cyc; end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit we, input bit bo, input logic [31:0] a,
                        input logic [31:0] wd);
      MemWrite  = we;
      ByteOp    = bo;
      Addr      = a;
      WriteData = wd;
   endtask

   // One-cycle request pulse, then enough idle cycles for both latencies.
   task automatic access(input bit we, input bit bo, input logic [31:0] a,
                         input logic [31:0] wd, output int k);
      drive(we, bo, a, wd);
      MemReq = 1'b1;
      tick();
      k = cyc;
      MemReq = 1'b0;
      repeat (5) tick();
   endtask

   int k;
   int base_a, base_b;
   logic [31:0] byte_exp [4] = '{32'h0D, 32'hF0, 32'hFE, 32'hCA};

   initial begin
      reset = 1'b1;
      MemReq = 1'b0;
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      checking = 1'b1;
      tick();
      tick();
      chk("reset_rd",   0, rd_a, 32'h0);
      chk("reset_ack",  0, {31'b0, ack_a}, 32'h0);
      chk("reset_busy", 1, {31'b0, busy_b}, 32'h0);
      reset = 1'b0;
      tick();

      // Word store then word load, with ack latency.
      access(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, k);
      chk("store_ack_lat", 0, 32'(last_ack[0] - k), 32'd3);
      chk("store_ack_lat", 1, 32'(last_ack[1] - k), 32'd1);
      access(1'b0, 1'b0, 32'h10, 32'h0, k);
      chk("load_ack_lat", 0, 32'(last_ack[0] - k), 32'd3);
      chk("load_ack_lat", 1, 32'(last_ack[1] - k), 32'd1);
      chk("load_word", 0, rd_a, 32'hDEADBEEF);
      chk("load_word", 1, rd_b, 32'hDEADBEEF);

      // Byte merge; word load with nonzero lane uses the whole word.
      access(1'b1, 1'b0, 32'h10, 32'h11223344, k);
      access(1'b1, 1'b1, 32'h12, 32'hFFFFFFAA, k);
      chk("store_keeps_rd", 0, rd_a, 32'hDEADBEEF);
      access(1'b0, 1'b0, 32'h13, 32'h0, k);
      chk("byte_merge", 0, rd_a, 32'h11AA3344);
      chk("byte_merge", 1, rd_b, 32'h11AA3344);

      // Byte loads, zero-extended.
      access(1'b1, 1'b0, 32'h20, 32'hCAFEF00D, k);
      for (int i = 0; i < 4; i++) begin
         access(1'b0, 1'b1, 32'h20 + 32'(i), 32'h0, k);
         chk("byte_load", 0, rd_a, byte_exp[i]);
         chk("byte_load", 1, rd_b, byte_exp[i]);
      end

      // Reset one cycle after a store is accepted aborts it.
      access(1'b1, 1'b0, 32'h30, 32'h5A5A5A5A, k);
      base_a = ackcnt[0];
      base_b = ackcnt[1];
      drive(1'b1, 1'b0, 32'h30, 32'h12345678);
      MemReq = 1'b1;
      tick();
      MemReq = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      repeat (5) tick();
      chk("abort_no_ack", 0, 32'(ackcnt[0] - base_a), 32'd0);
      chk("abort_no_ack", 1, 32'(ackcnt[1] - base_b), 32'd0);
      chk("abort_rd_reset", 0, rd_a, 32'h0);
      access(1'b0, 1'b0, 32'h30, 32'h0, k);
      chk("abort_old_data", 0, rd_a, 32'h5A5A5A5A);
      chk("abort_old_data", 1, rd_b, 32'h5A5A5A5A);

      // Request while busy is ignored.
      base_a = ackcnt[0];
      base_b = ackcnt[1];
      drive(1'b0, 1'b0, 32'h20, 32'h0);
      MemReq = 1'b1;
      tick();
      MemReq = 1'b0;
      tick();
      drive(1'b0, 1'b0, 32'h30, 32'h0);
      MemReq = 1'b1;
      tick();
      MemReq = 1'b0;
      repeat (5) tick();
      chk("busy_ignore_acks", 0, 32'(ackcnt[0] - base_a), 32'd1);
      chk("busy_ignore_acks", 1, 32'(ackcnt[1] - base_b), 32'd1);
      chk("busy_ignore_rd", 0, rd_a, 32'hCAFEF00D);
      chk("busy_ignore_rd", 1, rd_b, 32'hCAFEF00D);

      // Address wrap: 0x104 aliases 0x04.
      access(1'b1, 1'b0, 32'h104, 32'h0BADF00D, k);
      access(1'b0, 1'b0, 32'h04, 32'h0, k);
      chk("wrap", 0, rd_a, 32'h0BADF00D);
      chk("wrap", 1, rd_b, 32'h0BADF00D);

      // Request held for 7 edges is re-accepted after each DONE.
      base_a = ackcnt[0];
      base_b = ackcnt[1];
      drive(1'b0, 1'b0, 32'h10, 32'h0);
      MemReq = 1'b1;
      repeat (7) tick();
      MemReq = 1'b0;
      repeat (5) tick();
      chk("held_req_acks", 0, 32'(ackcnt[0] - base_a), 32'd2);
      chk("held_req_acks", 1, 32'(ackcnt[1] - base_b), 32'd3);
      chk("held_req_rd", 0, rd_a, 32'h11AA3344);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
